// File: rtl/friscv_uart_bridge.sv
// Byte-stream to register-bus bridge for the FRISCV UART.
// After reset it programs the baud divider and the control register, then
// polls the status register and moves single bytes between the tx/rx
// streams and the UART data registers. RX and TX take turns when both are ready.
module friscv_uart_bridge #(
  parameter int         ADDRW       = 16,
  parameter int         XLEN        = 32,
  parameter int         CLK_DIVIDER = 4,
  parameter logic [7:0] CTRL_CFG    = 8'h01
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [7:0]        tx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [7:0]        rx_data,
  output logic              mst_en,
  output logic              mst_wr,
  output logic [ADDRW-1:0]  mst_addr,
  output logic [XLEN-1:0]   mst_wdata,
  output logic [XLEN/8-1:0] mst_strb,
  input  logic [XLEN-1:0]   mst_rdata,
  input  logic              mst_ready,
  output logic              cfg_done
);

  localparam int STRBW = XLEN / 8;

  localparam logic [2:0] CFG_DIV  = 3'd0;
  localparam logic [2:0] CFG_CTRL = 3'd1;
  localparam logic [2:0] STATUS   = 3'd2;
  localparam logic [2:0] ARB      = 3'd3;
  localparam logic [2:0] TX_WR    = 3'd4;
  localparam logic [2:0] RX_RD    = 3'd5;

  localparam logic [ADDRW-1:0] ADDR_CTRL = '0;
  localparam logic [ADDRW-1:0] ADDR_DIV  = {{(ADDRW-2){1'b0}}, 2'd1};
  localparam logic [ADDRW-1:0] ADDR_TX   = {{(ADDRW-2){1'b0}}, 2'd2};
  localparam logic [ADDRW-1:0] ADDR_RX   = {{(ADDRW-2){1'b0}}, 2'd3};

  localparam logic [STRBW-1:0] STRB_B0  = {{(STRBW-1){1'b0}}, 1'b1};
  localparam logic [STRBW-1:0] STRB_B01 = {{(STRBW-2){1'b0}}, 2'b11};

  localparam logic [15:0]     DIV16      = 16'(CLK_DIVIDER);
  localparam logic [XLEN-1:0] WDATA_DIV  = {{(XLEN-16){1'b0}}, DIV16};
  localparam logic [XLEN-1:0] WDATA_CTRL = {{(XLEN-8){1'b0}}, CTRL_CFG};

  logic [2:0] state;
  logic       tx_full;
  logic       rx_empty;
  logic       last_tx;      // 1: TX was granted most recently
  logic       hs;
  logic       rx_elig;
  logic       tx_elig;
  logic       unused_rdata;

  assign hs           = mst_en & mst_ready;
  // RX is only eligible while the one-entry output buffer is free
  assign rx_elig      = ~rx_empty & ~rx_valid;
  assign tx_elig      = tx_valid & ~tx_full;
  assign unused_rdata = ^mst_rdata;

  // Sequencer: each request state raises one bus request while mst_en is low,
  // holds it until mst_ready is sampled, then drops mst_en and moves on, so
  // the next request always starts after at least one idle cycle.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= CFG_DIV;
      mst_en    <= 1'b0;
      mst_wr    <= 1'b0;
      mst_addr  <= '0;
      mst_wdata <= '0;
      mst_strb  <= '0;
      tx_full   <= 1'b1;
      rx_empty  <= 1'b1;
      last_tx   <= 1'b1;
    end else begin
      case (state)
        CFG_DIV: begin
          if (!mst_en) begin
            mst_en    <= 1'b1;
            mst_wr    <= 1'b1;
            mst_addr  <= ADDR_DIV;
            mst_wdata <= WDATA_DIV;
            mst_strb  <= STRB_B01;
          end else if (mst_ready) begin
            mst_en <= 1'b0;
            state  <= CFG_CTRL;
          end
        end
        CFG_CTRL: begin
          if (!mst_en) begin
            mst_en    <= 1'b1;
            mst_wr    <= 1'b1;
            mst_addr  <= ADDR_CTRL;
            mst_wdata <= WDATA_CTRL;
            mst_strb  <= STRB_B0;
          end else if (mst_ready) begin
            mst_en <= 1'b0;
            state  <= STATUS;
          end
        end
        STATUS: begin
          if (!mst_en) begin
            mst_en    <= 1'b1;
            mst_wr    <= 1'b0;
            mst_addr  <= ADDR_CTRL;
            mst_wdata <= '0;
            mst_strb  <= '0;
          end else if (mst_ready) begin
            mst_en   <= 1'b0;
            tx_full  <= mst_rdata[10];
            rx_empty <= mst_rdata[11];
            state    <= ARB;
          end
        end
        ARB: begin
          if (rx_elig && tx_elig) begin
            state   <= last_tx ? RX_RD : TX_WR;
            last_tx <= ~last_tx;
          end else if (rx_elig) begin
            state   <= RX_RD;
            last_tx <= 1'b0;
          end else if (tx_elig) begin
            state   <= TX_WR;
            last_tx <= 1'b1;
          end else begin
            state <= STATUS;
          end
        end
        TX_WR: begin
          // tx_data is captured here, so a later drop of tx_valid is harmless
          if (!mst_en) begin
            mst_en    <= 1'b1;
            mst_wr    <= 1'b1;
            mst_addr  <= ADDR_TX;
            mst_wdata <= {{(XLEN-8){1'b0}}, tx_data};
            mst_strb  <= STRB_B0;
          end else if (mst_ready) begin
            mst_en <= 1'b0;
            state  <= STATUS;
          end
        end
        RX_RD: begin
          if (!mst_en) begin
            mst_en    <= 1'b1;
            mst_wr    <= 1'b0;
            mst_addr  <= ADDR_RX;
            mst_wdata <= '0;
            mst_strb  <= '0;
          end else if (mst_ready) begin
            mst_en <= 1'b0;
            state  <= STATUS;
          end
        end
        default: begin
          mst_en <= 1'b0;
          state  <= CFG_DIV;
        end
      endcase
    end
  end

  // Stream side: one-cycle tx accept pulse, rx holding buffer, sticky cfg_done
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      cfg_done <= 1'b0;
    end else begin
      tx_ready <= hs && (state == TX_WR);
      if (hs && (state == RX_RD)) begin
        rx_valid <= 1'b1;
        rx_data  <= mst_rdata[7:0];
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (hs && (state == CFG_CTRL)) begin
        cfg_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_friscv_uart_bridge.sv
// Bench for friscv_uart_bridge: a register-bus slave model with programmable
// latency, a table of arbitration vectors, randomized vectors predicted by a
// round-robin reference model, and directed reset/config/rx-hold sequences.
module tb_friscv_uart_bridge;

  localparam int K_NONE = 0;
  localparam int K_TX   = 2;
  localparam int K_RX   = 3;
  localparam logic [31:0] IDLE = 32'h0C00;  // tx full, rx empty

  typedef struct {
    logic [31:0] status;
    logic        txv;
    logic [7:0]  txd;
    logic [7:0]  rxb;
    int          kind;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } op_t;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  tx_data = 8'h00;
  logic        rx_valid;
  logic        rx_ready = 1'b1;
  logic [7:0]  rx_data;
  logic        mst_en;
  logic        mst_wr;
  logic [15:0] mst_addr;
  logic [31:0] mst_wdata;
  logic [3:0]  mst_strb;
  logic [31:0] mst_rdata = 32'h0;
  logic        mst_ready = 1'b0;
  logic        cfg_done;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] status_word = IDLE;
  logic [7:0]  rx_byte = 8'h00;
  int          lat = 2;
  int          wait_cnt = 0;
  int          status_reads = 0;
  int          tx_pulses = 0;
  bit          status_seen = 1'b0;
  bit          last_hs_tx = 1'b0;
  bit          model_last_tx = 1'b1;
  op_t         cap;
  op_t         op_q[$];
  vec_t        tbl[11];

  friscv_uart_bridge #(
    .ADDRW(16), .XLEN(32), .CLK_DIVIDER(4), .CTRL_CFG(8'h01)
  ) dut (
    .aclk(clk), .aresetn(aresetn),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .mst_en(mst_en), .mst_wr(mst_wr), .mst_addr(mst_addr),
    .mst_wdata(mst_wdata), .mst_strb(mst_strb), .mst_rdata(mst_rdata),
    .mst_ready(mst_ready), .cfg_done(cfg_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Register-bus slave: answers each request after `lat` idle cycles, returns
  // status_word for addr-0 reads and rx_byte for addr-3 reads, logs all other
  // accesses and checks the handshake rules seen from the slave side.
  always @(negedge clk) begin
    if (tx_ready) tx_pulses++;
    if (mst_ready) begin
      mst_ready = 1'b0;
      check("en_low_after_ready", 64'(mst_en), 64'd0);
      if (last_hs_tx) check("tx_ready_after_wr", 64'(tx_ready), 64'd1);
      last_hs_tx = 1'b0;
    end else if (mst_en && aresetn) begin
      if (wait_cnt == 0) begin
        cap.wr = mst_wr; cap.addr = mst_addr; cap.wdata = mst_wdata; cap.strb = mst_strb;
      end
      if (wait_cnt >= lat) begin
        check("req_stable", {11'd0, mst_wr, mst_addr, mst_strb, mst_wdata},
              {11'd0, cap.wr, cap.addr, cap.strb, cap.wdata});
        mst_ready  = 1'b1;
        last_hs_tx = mst_wr && (mst_addr == 16'd2);
        if (!mst_wr && mst_addr == 16'd0) begin
          mst_rdata = status_word;
          status_reads++;
          status_seen = 1'b1;
          check("status_strb", 64'(mst_strb), 64'd0);
        end else begin
          mst_rdata = (mst_addr == 16'd3) ? {24'h0, rx_byte} : 32'h0;
          if (mst_addr == 16'd2 || mst_addr == 16'd3) begin
            check("status_before_op", 64'(status_seen), 64'd1);
            status_seen = 1'b0;
          end
          op_q.push_back(cap);
        end
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic wait_op(input int budget, output bit got);
    got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      @(negedge clk);
      if (op_q.size() != 0) got = 1'b1;
    end
  endtask

  // Apply one vector, observe the first non-status access, then return to idle.
  task automatic run_vec(input vec_t v);
    bit  got;
    int  p0;
    op_t o;
    @(negedge clk);
    op_q.delete();
    p0 = tx_pulses;
    status_word = v.status; tx_valid = v.txv; tx_data = v.txd; rx_byte = v.rxb;
    wait_op(80, got);
    status_word = IDLE;
    tx_valid = 1'b0;
    if (v.kind == K_NONE) begin
      check("no_op_expected", 64'(got), 64'd0);
    end else begin
      check("op_seen", 64'(got), 64'd1);
      if (got) begin
        o = op_q[0];
        check("op_addr", 64'(o.addr), 64'(v.kind));
        check("op_wr", 64'(o.wr), (v.kind == K_TX) ? 64'd1 : 64'd0);
        if (v.kind == K_TX) begin
          check("tx_wdata", 64'(o.wdata), {56'd0, v.txd});
          check("tx_strb", 64'(o.strb), 64'd1);
        end
      end
    end
    repeat (12) @(negedge clk);
    check("tx_pulses", 64'(tx_pulses - p0), (v.kind == K_TX) ? 64'd1 : 64'd0);
    if (v.kind == K_RX) check("rx_data", 64'(rx_data), 64'(v.rxb));
    if (v.kind == K_TX) model_last_tx = 1'b1;
    if (v.kind == K_RX) model_last_tx = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit  got;
    int  p0;
    int  s0;

    tbl[0]  = '{32'h0200, 1'b1, 8'h11, 8'hA5, K_RX};
    tbl[1]  = '{32'h0200, 1'b1, 8'h22, 8'h00, K_TX};
    tbl[2]  = '{32'h0200, 1'b1, 8'h33, 8'h5A, K_RX};
    tbl[3]  = '{32'h0200, 1'b1, 8'h44, 8'h00, K_TX};
    tbl[4]  = '{32'h0A00, 1'b1, 8'h55, 8'h00, K_TX};
    tbl[5]  = '{32'h0200, 1'b0, 8'h00, 8'h3C, K_RX};
    tbl[6]  = '{32'h0E00, 1'b1, 8'h66, 8'h00, K_NONE};
    tbl[7]  = '{32'h0400, 1'b1, 8'h77, 8'h81, K_RX};
    tbl[8]  = '{32'h0800, 1'b1, 8'h99, 8'h00, K_TX};
    tbl[9]  = '{32'h0000, 1'b0, 8'h00, 8'h00, K_RX};
    tbl[10] = '{32'h0000, 1'b1, 8'hFE, 8'h7F, K_TX};

    // Reset values, then startup configuration with tx_valid already high
    aresetn = 1'b0; tx_valid = 1'b1; tx_data = 8'h42; status_word = IDLE;
    repeat (3) @(negedge clk);
    check("rst_mst_en", 64'(mst_en), 64'd0);
    check("rst_mst_wr", 64'(mst_wr), 64'd0);
    check("rst_mst_addr", 64'(mst_addr), 64'd0);
    check("rst_mst_wdata", 64'(mst_wdata), 64'd0);
    check("rst_mst_strb", 64'(mst_strb), 64'd0);
    check("rst_tx_ready", 64'(tx_ready), 64'd0);
    check("rst_rx_valid", 64'(rx_valid), 64'd0);
    check("rst_rx_data", 64'(rx_data), 64'd0);
    check("rst_cfg_done", 64'(cfg_done), 64'd0);
    aresetn = 1'b1;
    check("en_before_edge", 64'(mst_en), 64'd0);
    @(negedge clk);
    check("first_en", 64'(mst_en), 64'd1);
    check("first_addr", 64'(mst_addr), 64'd1);
    check("cfg_done_early", 64'(cfg_done), 64'd0);
    for (int c = 0; c < 600 && status_reads < 20; c++) @(negedge clk);
    check("polls_reached", 64'(status_reads >= 20), 64'd1);
    check("cfg_op_count", 64'(op_q.size()), 64'd2);
    if (op_q.size() >= 2) begin
      check("cfg_div", {op_q[0].wr, op_q[0].addr, op_q[0].strb, op_q[0].wdata},
            {1'b1, 16'd1, 4'h3, 32'h0004});
      check("cfg_ctrl", {op_q[1].wr, op_q[1].addr, op_q[1].strb, op_q[1].wdata},
            {1'b1, 16'd0, 4'h1, 32'h0001});
    end
    check("cfg_done_set", 64'(cfg_done), 64'd1);
    check("tx_held_while_full", 64'(tx_pulses), 64'd0);
    check("rx_valid_idle", 64'(rx_valid), 64'd0);

    // tx no longer full: the pending byte goes out
    run_vec('{32'h0A00, 1'b1, 8'h55, 8'h00, K_TX});

    // Table vectors: alternation and single-source cases
    for (int i = 0; i < 11; i++) run_vec(tbl[i]);

    // RX buffer held while rx_ready=0; no second addr-3 read meanwhile
    @(negedge clk);
    rx_ready = 1'b0; op_q.delete();
    status_word = 32'h0200; tx_valid = 1'b0; rx_byte = 8'hA5;
    wait_op(80, got);
    check("rxh_op_seen", 64'(got), 64'd1);
    if (got) check("rxh_addr", 64'(op_q[0].addr), 64'd3);
    repeat (30) @(negedge clk);
    check("rxh_single_read", 64'(op_q.size()), 64'd1);
    check("rxh_valid", 64'(rx_valid), 64'd1);
    check("rxh_data", 64'(rx_data), 64'hA5);
    status_word = IDLE;
    repeat (12) @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    check("rxh_drain", 64'(rx_valid), 64'd0);
    model_last_tx = 1'b0;
    repeat (12) @(negedge clk);

    // Randomized vectors against the round-robin reference model
    for (int i = 0; i < 30; i++) begin
      vec_t v;
      bit   tf, re, rx_e, tx_e;
      tf = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      v.status = 32'h0;
      v.status[11] = re;
      v.status[10] = tf;
      v.status[9]  = 1'($urandom_range(0, 1));
      v.txv = 1'($urandom_range(0, 1));
      v.txd = 8'($urandom);
      v.rxb = 8'($urandom);
      rx_e = !re;
      tx_e = v.txv && !tf;
      if (rx_e && tx_e) v.kind = model_last_tx ? K_RX : K_TX;
      else if (rx_e)    v.kind = K_RX;
      else if (tx_e)    v.kind = K_TX;
      else              v.kind = K_NONE;
      lat = $urandom_range(0, 3);
      run_vec(v);
    end
    lat = 2;

    // Reset while a TX write is outstanding
    @(negedge clk);
    op_q.delete();
    status_word = 32'h0A00; tx_valid = 1'b1; tx_data = 8'h77;
    got = 1'b0;
    for (int c = 0; c < 80 && !got; c++) begin
      @(negedge clk);
      if (mst_en && mst_addr == 16'd2) got = 1'b1;
    end
    check("mid_addr2_seen", 64'(got), 64'd1);
    aresetn = 1'b0;
    p0 = tx_pulses;
    @(negedge clk);
    check("mid_en_drop", 64'(mst_en), 64'd0);
    check("mid_cfg_done", 64'(cfg_done), 64'd0);
    repeat (3) @(negedge clk);
    tx_valid = 1'b0; status_word = IDLE; op_q.delete();
    s0 = status_reads;
    aresetn = 1'b1;
    wait_op(40, got);
    check("mid_restart_seen", 64'(got), 64'd1);
    if (got) check("mid_restart_op", {op_q[0].wr, op_q[0].addr, op_q[0].wdata},
                   {1'b1, 16'd1, 32'h0004});
    repeat (20) @(negedge clk);
    check("mid_no_tx_pulse", 64'(tx_pulses - p0), 64'd0);
    check("mid_cfg_again", 64'(cfg_done), 64'd1);
    check("mid_polling", 64'(status_reads > s0), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/friscv_uart_bridge.md
FRISCV_UART_BRIDGE -- requirements
Module: friscv_uart_bridge

Interface
REQ-001 SHALL have parameters: ADDRW, 16, register-bus address width; XLEN, 32, register-bus data width; CLK_DIVIDER, 4, baud divider written at startup; CTRL_CFG, 8'h01, control byte written at startup (enable=1, loopback/parity/stop=0).
REQ-002 SHALL have ports: aclk  in  1  clock; aresetn  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: tx_valid  in  1; tx_ready  out  1; tx_data  in  8  byte stream to transmit.
REQ-004 SHALL have ports: rx_valid  out  1; rx_ready  in  1; rx_data  out  8  received byte stream.
REQ-005 SHALL have ports: mst_en  out  1; mst_wr  out  1; mst_addr  out  ADDRW; mst_wdata  out  XLEN; mst_strb  out  XLEN/8; mst_rdata  in  XLEN; mst_ready  in  1  register-bus master toward UART.
REQ-006 SHALL have port: cfg_done  out  1  startup configuration complete.

Function
REQ-007 Bus handshake SHALL be: mst_en, mst_wr, mst_addr, mst_wdata and mst_strb registered and held stable from assertion until the cycle mst_ready=1 is sampled; mst_en SHALL be 0 in the following cycle; at least one mst_en=0 cycle SHALL separate requests.
REQ-008 FSM states SHALL be CFG_DIV, CFG_CTRL, STATUS, ARB, TX_WR, RX_RD.
REQ-009 CFG_DIV SHALL write addr 1, wdata={XLEN-16 zeros, CLK_DIVIDER[15:0]}, strb=0b0011; on mst_ready go to CFG_CTRL.
REQ-010 CFG_CTRL SHALL write addr 0, wdata={zeros, CTRL_CFG}, strb=0b0001; on mst_ready set cfg_done=1 (sticky until reset) and go to STATUS.
REQ-011 STATUS SHALL read addr 0 (mst_wr=0, strb=0); on mst_ready capture tx_full=mst_rdata[10], rx_empty=mst_rdata[11], go to ARB.
REQ-012 ARB (one cycle) SHALL compute rx_elig = ~rx_empty & ~rx_valid and tx_elig = tx_valid & ~tx_full; neither -> STATUS; one -> its state; both -> the one not served last (last_served flag, reset value TX so RX wins first).
REQ-013 TX_WR SHALL write addr 2, wdata={zeros, tx_data}, strb=0b0001; tx_data SHALL be sampled into the request at issue; tx_ready SHALL pulse 1 for exactly the cycle after mst_ready is sampled; then STATUS.
REQ-014 tx_ready SHALL be 0 in all other cycles; no TX write SHALL issue without a fresh STATUS showing tx_full=0.
REQ-015 RX_RD SHALL read addr 3; on mst_ready capture mst_rdata[7:0] into rx_data, set rx_valid=1, go to STATUS.
REQ-016 rx_valid/rx_data SHALL hold until rx_valid&rx_ready, then rx_valid=0 next cycle; one-entry buffer, no further addr-3 read while rx_valid=1.
REQ-017 Every request SHALL be preceded by a STATUS read; addr 2 and 3 accesses thus never block on the slave.
REQ-018 tx_valid deasserted while in TX_WR SHALL not abort the write (data already latched).
REQ-019 Before cfg_done=1, tx_ready SHALL stay 0 and rx_valid SHALL stay 0.

Reset
REQ-020 On aresetn=0 sampled at a rising aclk edge: state=CFG_DIV, mst_en=0, mst_wr=0, mst_addr=0, mst_wdata=0, mst_strb=0, tx_ready=0, rx_valid=0, rx_data=0, cfg_done=0, tx_full=1, rx_empty=1, last_served=TX.
REQ-021 Reset mid-transaction SHALL drop mst_en the next cycle and restart at CFG_DIV; first mst_en SHALL assert the cycle after aresetn is seen 1.

Verification
REQ-022 Reset release, slave answers each request after 2 cycles -> write addr1 wdata 0x0004 strb 0x3, write addr0 wdata 0x01 strb 0x1, cfg_done=1, then addr0 reads loop.
REQ-023 tx_valid=1 tx_data=0x55, status 0x0A00 returned (tx_empty, rx_empty) -> write addr2 wdata 0x55 strb 0x1, single tx_ready pulse.
REQ-024 Status 0x0C00 (tx_full=1), tx_valid=1 for 20 polls -> only addr0 reads, tx_ready stays 0; status 0x0A00 -> addr2 write issues.
REQ-025 Status 0x0200 (rx not empty), addr3 returns 0xA5, rx_ready=0 -> rx_valid=1 rx_data=0xA5 held, no second addr3 read; rx_ready=1 -> rx_valid=0 next cycle.
REQ-026 Both eligible repeatedly (status 0x0200, tx_valid=1) -> order addr3, addr2, addr3, addr2 with STATUS reads between.
REQ-027 aresetn=0 while mst_en=1 on addr2 -> mst_en=0 next cycle, no tx_ready pulse, sequence restarts with addr1 write.
